imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time program loader for the single_cycle MIPS core.
- Receives a length-prefixed byte stream over a valid/ready interface and assembles big-endian 32-bit words.
- Writes each word into instruction memory through a one-cycle write strobe.
- Holds the CPU in reset until the whole image is written, then releases it.
- It is the write side of the instruction-memory/CPU-control interface that simulation benches drive directly today.

Parameters:
- ADDR_WIDTH, 8: width of the instruction-memory word address; capacity is 2**ADDR_WIDTH words.
- BASE_ADDR, 0: word address of the first loaded instruction.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous reload request, sampled each rising edge.
- in_valid  in  1  source presents a byte.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts a byte; a byte transfers on a rising edge where in_valid && in_ready.
- imem_we  out  1  instruction-memory write strobe, exactly one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  instruction word for the write.
- cpu_reset  out  1  active-high reset to the CPU.
- done  out  1  image loaded, CPU released.
- error  out  1  length rejected.

Behaviour:
- States: INIT, LEN_HI, LEN_LO, WORD, WRITE, DONE, ERR.
- reset low (any time, asynchronous):
  - state=INIT; len, word_idx, byte_cnt and shift register cleared.
  - Outputs: imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, in_ready=0.
- in_ready is combinational: (state is LEN_HI, LEN_LO or WORD) && !restart.
- imem_we, imem_addr, imem_wdata, cpu_reset, done and error are registered.
- INIT → LEN_HI unconditionally on the next edge.
- LEN_HI: on transfer, len[15:8]=in_data; go to LEN_LO.
- LEN_LO: on transfer, len[7:0]=in_data. Then:
  - len==0 → DONE.
  - len > 2**ADDR_WIDTH − BASE_ADDR → ERR.
  - otherwise → WORD with byte_cnt=0, word_idx=0.
- WORD: each transfer shifts in_data into the word, MSB first (first byte → bits 31:24).
  - byte_cnt increments on each transfer.
  - On the 4th byte → WRITE.
- WRITE, one cycle:
  - imem_we=1, imem_addr=BASE_ADDR+word_idx (mod 2**ADDR_WIDTH), imem_wdata=assembled word.
  - word_idx increments.
  - If word_idx+1==len → DONE, else → WORD with byte_cnt=0.
- Latency: imem_we is asserted the cycle after the edge that accepts the 4th byte of a word.
- Minimum 5 cycles per word (4 accept cycles + 1 WRITE).
- in_valid gaps stall the loader without losing state.
- imem_we is 0 in every state except WRITE. imem_addr and imem_wdata hold their last values outside WRITE.
- DONE:
  - cpu_reset=0, done=1; in_ready=0.
  - Stays in DONE until reset or restart; input bytes are ignored.
- ERR:
  - error=1, cpu_reset=1, done=0; in_ready=0.
  - Stays in ERR until reset or restart.
- cpu_reset is 1 in INIT, LEN_HI, LEN_LO, WORD, WRITE and ERR. It falls on the same edge that enters DONE.
- restart=1 at an edge, in any state:
  - Go to INIT; clear counters; cpu_reset=1, done=0, error=0, imem_we=0.
  - restart wins over a simultaneous byte; the byte is not consumed because in_ready=0.
- A partial word in progress at restart or reset is discarded and never written.
- Words already written are not erased.
- Full-capacity case: len == 2**ADDR_WIDTH − BASE_ADDR is legal. The last write goes to address 2**ADDR_WIDTH−1 with no wrap.

Test Plan:
- Normal load:
  - Stimulus: stream 00 03, 20 08 00 05, 20 09 00 07, 01 09 50 20 with in_valid held high.
  - Required: three imem_we pulses at addr 0,1,2 with data 0x20080005, 0x20090007, 0x01095020.
  - Required: cpu_reset falls and done rises on the edge after the third WRITE cycle.
- Zero length:
  - Stimulus: stream 00 00.
  - Required: no imem_we; done=1 and cpu_reset=0 on the edge after LEN_LO accept; in_ready=0 afterwards.
- Oversize length (ADDR_WIDTH=8, BASE_ADDR=0):
  - Stimulus: stream 01 01 (257 words).
  - Required: error=1, cpu_reset stays 1, no imem_we.
  - Then restart pulse followed by 00 01 DE AD BE EF → single write addr 0 data 0xDEADBEEF, done=1.
- Backpressure:
  - Stimulus: same image as normal load with in_valid toggled randomly.
  - Required: identical writes and order.
  - Required: in_ready low during each WRITE cycle; no byte dropped or duplicated.
- Restart mid-word:
  - Stimulus: after 00 02 and bytes AA BB, assert restart in the same cycle as in_valid with byte CC.
  - Required: in_ready=0 that cycle; no write occurs.
  - Required: a fresh load of 00 01 11 22 33 44 then writes 0x11223344 at addr 0.
- Async reset mid-load:
  - Stimulus: pull reset low between clock edges during WORD.
  - Required: outputs go to their reset values immediately (cpu_reset=1, imem_we=0, in_ready=0) without waiting for a clock edge.
  - Required: after release, one INIT cycle, then in_ready=1 in LEN_HI.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream to big-endian imem words.
// Holds the CPU in reset until the full image has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    INIT, LEN_HI, LEN_LO, WORD, WRITE, DONE, ERR
  } state_e;

  localparam logic [63:0] CAP =
    (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);

  state_e state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  crst_q, crst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        xfer;
  logic [15:0] len_new;

  assign in_ready = (state_q == LEN_HI || state_q == LEN_LO ||
                     state_q == WORD) && !restart;
  assign xfer     = in_valid && in_ready;
  assign len_new  = {len_q[15:8], in_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (restart) begin
      state_d = INIT;
      len_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        INIT: state_d = LEN_HI;
        LEN_HI: if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = LEN_LO;
        end
        LEN_LO: if (xfer) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = DONE;
          end else if (64'(len_new) > CAP) begin
            state_d = ERR;
          end else begin
            state_d = WORD;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        WORD: if (xfer) begin
          shift_d = {shift_q[15:0], in_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WRITE;
        end
        WRITE: begin
          idx_d = idx_q + 16'd1;
          if (idx_q + 16'd1 == len_q) begin
            state_d = DONE;
          end else begin
            state_d = WORD;
            cnt_d   = '0;
          end
        end
        DONE:    state_d = DONE;
        ERR:     state_d = ERR;
        default: state_d = INIT;
      endcase
    end
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    we_d    = (state_d == WRITE);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (we_d) begin
      addr_d  = BASE + ADDR_WIDTH'(idx_q);
      wdata_d = {shift_q, in_data};
    end
    crst_d = (state_d != DONE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = crst_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule
